// File: rtl/uart_rx_bit_timer_if.sv
// uart_rx_bit_timer_if: control and status bundle
// between the RX front end and the bit timer.
interface uart_rx_bit_timer_if #(
  parameter int PRESCALE_W = 6,
  parameter int FRAME_W    = 4
);
  logic                  enable;
  logic                  restart;
  logic [PRESCALE_W-1:0] prescale;
  logic [FRAME_W-1:0]    frame_bits;
  logic [PRESCALE_W-1:0] edge_count;
  logic                  edge_count_done;
  logic [FRAME_W-1:0]    bit_count;
  logic                  sample_early;
  logic                  sample_mid;
  logic                  sample_late;
  logic                  frame_done;
  logic                  busy;
  logic                  prescale_err;

  modport master (
    output enable, restart, prescale, frame_bits,
    input  edge_count, edge_count_done, bit_count,
    input  sample_early, sample_mid, sample_late,
    input  frame_done, busy, prescale_err
  );

  modport slave (
    input  enable, restart, prescale, frame_bits,
    output edge_count, edge_count_done, bit_count,
    output sample_early, sample_mid, sample_late,
    output frame_done, busy, prescale_err
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: oversampling edge/bit counter
// with mid-bit vote strobes and frame-end flag.
module uart_rx_bit_timer #(
  parameter int PRESCALE_W   = 6,
  parameter int MAX_PRESCALE = 32,
  parameter int FRAME_W      = 4
) (
  input  logic UCLK,
  input  logic reset,
  uart_rx_bit_timer_if.slave bus
);

  localparam int PW = PRESCALE_W;
  localparam int FW = FRAME_W;
  localparam logic [PW:0] LP_MAX =
    (PW+1)'(MAX_PRESCALE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ERR
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_edge, w_edge_nxt;
  logic [PW-1:0] r_plat, w_plat_nxt;
  logic [FW-1:0] r_bit, w_bit_nxt;
  logic [FW-1:0] r_flat, w_flat_nxt;

  logic [PW-1:0] w_plast;
  logic [PW-1:0] w_half;
  logic [FW-1:0] w_flast;
  logic          w_run;
  logic          w_legal;
  logic          w_edge_done;
  logic          w_frame_end;

  assign w_run   = (r_state == S_RUN);
  assign w_plast = r_plat - PW'(1);
  assign w_half  = r_plat >> 1;
  assign w_flast = r_flat - FW'(1);

  assign w_legal =
    (bus.prescale >= PW'(4)) &&
    ({1'b0, bus.prescale} <= LP_MAX) &&
    !bus.prescale[0] &&
    (bus.frame_bits != '0);

  assign w_edge_done =
    w_run && (r_edge == w_plast);
  assign w_frame_end =
    w_edge_done && (r_bit == w_flast);

  // Next state, counters and config latch.
  always_comb begin
    w_state_nxt = r_state;
    w_edge_nxt  = r_edge;
    w_bit_nxt   = r_bit;
    w_plat_nxt  = r_plat;
    w_flat_nxt  = r_flat;
    unique case (r_state)
      S_IDLE: begin
        w_edge_nxt = '0;
        w_bit_nxt  = '0;
        if (bus.enable) begin
          if (w_legal) begin
            w_state_nxt = S_RUN;
            w_plat_nxt  = bus.prescale;
            w_flat_nxt  = bus.frame_bits;
          end else begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_RUN: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
          w_edge_nxt  = '0;
          w_bit_nxt   = '0;
        end else if (bus.restart) begin
          w_edge_nxt = '0;
          w_bit_nxt  = '0;
        end else if (w_frame_end) begin
          w_state_nxt = S_IDLE;
          w_edge_nxt  = '0;
          w_bit_nxt   = '0;
        end else if (w_edge_done) begin
          w_edge_nxt = '0;
          w_bit_nxt  = r_bit + FW'(1);
        end else begin
          w_edge_nxt = r_edge + PW'(1);
        end
      end
      S_ERR: begin
        w_edge_nxt = '0;
        w_bit_nxt  = '0;
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_edge_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // State, counter and config registers.
  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_edge  <= '0;
      r_bit   <= '0;
      r_plat  <= '0;
      r_flat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_edge  <= w_edge_nxt;
      r_bit   <= w_bit_nxt;
      r_plat  <= w_plat_nxt;
      r_flat  <= w_flat_nxt;
    end
  end

  assign bus.edge_count      = r_edge;
  assign bus.bit_count       = r_bit;
  assign bus.edge_count_done = w_edge_done;
  assign bus.busy            = w_run;
  assign bus.prescale_err    = (r_state == S_ERR);

  assign bus.sample_early =
    w_run && (r_edge == w_half - PW'(2));
  assign bus.sample_mid =
    w_run && (r_edge == w_half - PW'(1));
  assign bus.sample_late =
    w_run && (r_edge == w_half);

  // A resync on the final edge keeps the frame
  // alive, so it also cancels the end flag.
  assign bus.frame_done =
    w_frame_end && !bus.restart;

endmodule
